// File: rtl/snap_layer_sequencer_pkg.sv
// Shared definitions for the SqueezeNet layer sequencer.
//   state_e       : sequencer FSM states
//   layer_e       : fixed layer slot indices in execution order
//   DEFAULT_*     : default build parameters for the sequencer top
package snap_seq_pkg;

  localparam int unsigned DEFAULT_NUM_LAYERS     = 22;
  localparam int unsigned DEFAULT_LAYER_ADDR_W   = 128;
  localparam int unsigned DEFAULT_GAP_CYCLES     = 2;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 0;
  localparam int unsigned DEFAULT_CNT_W          = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_GAP    = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  // Slot 20 is a spare pass-through slot so CONV10 lands on the last index.
  typedef enum int unsigned {
    L_CONV1  = 0,
    L_POOL1  = 1,
    L_F2_S   = 2,
    L_F2_E   = 3,
    L_F3_S   = 4,
    L_F3_E   = 5,
    L_POOL3  = 6,
    L_F4_S   = 7,
    L_F4_E   = 8,
    L_F5_S   = 9,
    L_F5_E   = 10,
    L_POOL5  = 11,
    L_F6_S   = 12,
    L_F6_E   = 13,
    L_F7_S   = 14,
    L_F7_E   = 15,
    L_F8_S   = 16,
    L_F8_E   = 17,
    L_F9_S   = 18,
    L_F9_E   = 19,
    L_SPARE  = 20,
    L_CONV10 = 21
  } layer_e;

endpackage

// File: rtl/snap_layer_sequencer_watchdog.sv
// Loadable saturating down-counter shared by gap timing and the layer watchdog.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val (has priority over en)
//   load_val   : count to load
//   en         : decrement by one, stopping at zero
//   expire_c   : count is at or below one (last cycle of the loaded period)
module snap_seq_watchdog #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire_c
);

  logic [W-1:0] cnt;

  // Down-count, holding at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  // A period of N cycles ends on the cycle the count shows 1.
  assign expire_c = (cnt <= W'(1));

endmodule

// File: rtl/snap_layer_sequencer.sv
// Layer sequencer: issues each layer slot in order with its address word,
// waits for layer_done, inserts a drain gap, and reports run completion.
// Optional per-layer WAIT-cycle profiling when SNAP_LAYER_PROFILE_EN is defined.
//   ap_clk, ap_rst_n : clock, async active-low reset
//   sw_start/sw_done : run start pulse in / run complete pulse out
//   sw_abort         : abort request (ignored when idle)
//   layer_addr_flat  : NUM_LAYERS packed address words
//   layer_start/done : per-layer handshake with the datapath
//   layer_id/addr    : current layer index and its registered address word
//   busy             : run in progress
//   timeout_err      : sticky, last run ended by watchdog
//   abort_flag       : sticky, last run ended by abort
//   total_cycles     : saturating busy-cycle count of the last/current run
//   prof_sel/cycles  : profile slot select / that layer's WAIT-cycle count
module snap_layer_sequencer
  import snap_seq_pkg::*;
#(
  parameter int unsigned NUM_LAYERS     = DEFAULT_NUM_LAYERS,
  parameter int unsigned LAYER_ADDR_W   = DEFAULT_LAYER_ADDR_W,
  parameter int unsigned GAP_CYCLES     = DEFAULT_GAP_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = DEFAULT_CNT_W
) (
  input  logic                               ap_clk,
  input  logic                               ap_rst_n,
  input  logic                               sw_start,
  input  logic                               sw_abort,
  input  logic [NUM_LAYERS*LAYER_ADDR_W-1:0] layer_addr_flat,
  input  logic                               layer_done,
  output logic                               layer_start,
  output logic [$clog2(NUM_LAYERS)-1:0]      layer_id,
  output logic [LAYER_ADDR_W-1:0]            layer_addr,
  output logic                               busy,
  output logic                               sw_done,
  output logic                               timeout_err,
  output logic                               abort_flag,
  output logic [CNT_W-1:0]                   total_cycles,
  input  logic [$clog2(NUM_LAYERS)-1:0]      prof_sel,
  output logic [CNT_W-1:0]                   prof_cycles
);

  localparam int unsigned ID_W = $clog2(NUM_LAYERS);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_LAYERS - 1);

  state_e state_q, state_d;

  logic                    layer_start_d;
  logic [ID_W-1:0]         layer_id_d;
  logic [LAYER_ADDR_W-1:0] layer_addr_d;
  logic                    busy_d;
  logic                    sw_done_d;
  logic                    timeout_err_d;
  logic                    abort_flag_d;
  logic [CNT_W-1:0]        total_d;

  logic             start_c;
  logic             abort_c;
  logic             last_c;
  logic             timeout_c;
  logic             wd_load_c;
  logic             wd_en_c;
  logic [CNT_W-1:0] wd_load_val_c;
  logic             wd_expire_c;

  // Unpack the flat address bus into indexable slots.
  logic [LAYER_ADDR_W-1:0] slot [NUM_LAYERS];
  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_slot
    assign slot[g] = layer_addr_flat[g*LAYER_ADDR_W +: LAYER_ADDR_W];
  end

  assign start_c = (state_q == ST_IDLE) && sw_start;
  assign abort_c = (state_q != ST_IDLE) && sw_abort;
  assign last_c  = (layer_id == LAST_ID);
  // layer_done on the expiry cycle counts as normal completion.
  assign timeout_c = (TIMEOUT_CYCLES != 0) && (state_q == ST_WAIT) &&
                     !layer_done && wd_expire_c;

  // One counter serves both GAP and WAIT; reload on every entry to either.
  assign wd_load_c     = ((state_d == ST_GAP) || (state_d == ST_WAIT)) && (state_d != state_q);
  assign wd_load_val_c = (state_d == ST_GAP) ? CNT_W'(GAP_CYCLES) : CNT_W'(TIMEOUT_CYCLES);
  assign wd_en_c       = (state_q == ST_GAP) || (state_q == ST_WAIT);

  snap_seq_watchdog #(
    .W (CNT_W)
  ) u_watchdog (
    .clk      (ap_clk),
    .rst_n    (ap_rst_n),
    .load     (wd_load_c),
    .load_val (wd_load_val_c),
    .en       (wd_en_c),
    .expire_c (wd_expire_c)
  );

  // State and output registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q      <= ST_IDLE;
      layer_start  <= 1'b0;
      layer_id     <= '0;
      layer_addr   <= '0;
      busy         <= 1'b0;
      sw_done      <= 1'b0;
      timeout_err  <= 1'b0;
      abort_flag   <= 1'b0;
      total_cycles <= '0;
    end else begin
      state_q      <= state_d;
      layer_start  <= layer_start_d;
      layer_id     <= layer_id_d;
      layer_addr   <= layer_addr_d;
      busy         <= busy_d;
      sw_done      <= sw_done_d;
      timeout_err  <= timeout_err_d;
      abort_flag   <= abort_flag_d;
      total_cycles <= total_d;
    end
  end

  // Next-state logic; abort overrides everything outside IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (sw_start) state_d = ST_ISSUE;
      ST_ISSUE:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (layer_done) begin
          if (last_c)               state_d = ST_FINISH;
          else if (GAP_CYCLES == 0) state_d = ST_ISSUE;
          else                      state_d = ST_GAP;
        end else if (timeout_c) begin
          state_d = ST_FINISH;
        end
      end
      ST_GAP:    if (wd_expire_c) state_d = ST_ISSUE;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (abort_c) state_d = ST_IDLE;
  end

  // Output next values, derived from the state being entered.
  always_comb begin
    layer_id_d    = layer_id;
    layer_addr_d  = layer_addr;
    timeout_err_d = timeout_err;
    abort_flag_d  = abort_flag;
    total_d       = total_cycles;
    layer_start_d = (state_d == ST_ISSUE);
    busy_d        = (state_d == ST_ISSUE) || (state_d == ST_WAIT) || (state_d == ST_GAP);
    sw_done_d     = (state_d == ST_FINISH);

    if (start_c) begin
      layer_id_d    = '0;
      timeout_err_d = 1'b0;
      abort_flag_d  = 1'b0;
      total_d       = '0;
    end else begin
      if ((state_q != ST_IDLE) && (state_d == ST_ISSUE)) layer_id_d = layer_id + ID_W'(1);
      if (busy && (total_cycles != '1))                  total_d = total_cycles + CNT_W'(1);
      if (timeout_c && !abort_c)                         timeout_err_d = 1'b0 | 1'b1;
      if (abort_c)                                       abort_flag_d = 1'b1;
    end

    // Address word is captured only when a layer is issued.
    if (state_d == ST_ISSUE) layer_addr_d = slot[layer_id_d];
  end

`ifdef SNAP_LAYER_PROFILE_EN
  logic [CNT_W-1:0] prof_mem [NUM_LAYERS];
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_inc_c;
  logic             prof_capture_c;

  // wait_cnt_inc_c is the number of WAIT cycles including the current one.
  assign wait_cnt_inc_c = (wait_cnt == '1) ? wait_cnt : wait_cnt + CNT_W'(1);
  assign prof_capture_c = (state_q == ST_WAIT) && !abort_c && (layer_done || timeout_c);

  // Per-layer WAIT-cycle capture, cleared at run start.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wait_cnt <= '0;
      prof_mem <= '{default: '0};
    end else begin
      wait_cnt <= (state_q == ST_WAIT) ? wait_cnt_inc_c : '0;
      if (start_c) begin
        prof_mem <= '{default: '0};
      end else if (prof_capture_c) begin
        prof_mem[layer_id] <= wait_cnt_inc_c;
      end
    end
  end

  assign prof_cycles = (32'(prof_sel) < NUM_LAYERS) ? prof_mem[prof_sel] : '0;
`else
  logic unused_prof_sel;
  assign unused_prof_sel = ^prof_sel;
  assign prof_cycles     = '0;
`endif

endmodule

// File: tb/tb_snap_layer_sequencer.sv
// Self-checking bench for snap_layer_sequencer (GAP=2, TIMEOUT=50).
// A responder emulates the datapath; a monitor logs start/done events; the
// expected schedule is computed from per-layer latencies with plain arithmetic.
`timescale 1ns/1ps
module tb_snap_layer_sequencer;

  localparam int unsigned NL  = 22;
  localparam int unsigned AW  = 128;
  localparam int unsigned GAP = 2;
  localparam int unsigned TO  = 50;
  localparam int unsigned CW  = 32;
  localparam int unsigned IW  = 5;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n = 1'b0;
  logic              sw_start_main = 1'b0;
  logic              sw_start_poke = 1'b0;
  logic              sw_start;
  logic              sw_abort = 1'b0;
  logic [NL*AW-1:0]  addr_flat = '0;
  logic              layer_done = 1'b0;
  logic              layer_start;
  logic [IW-1:0]     layer_id;
  logic [AW-1:0]     layer_addr;
  logic              busy;
  logic              sw_done;
  logic              timeout_err;
  logic              abort_flag;
  logic [CW-1:0]     total_cycles;
  logic [IW-1:0]     prof_sel = '0;
  logic [CW-1:0]     prof_cycles;

  assign sw_start = sw_start_main | sw_start_poke;

  snap_layer_sequencer #(
    .NUM_LAYERS     (NL),
    .LAYER_ADDR_W   (AW),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CW)
  ) dut (
    .ap_clk          (ap_clk),
    .ap_rst_n        (ap_rst_n),
    .sw_start        (sw_start),
    .sw_abort        (sw_abort),
    .layer_addr_flat (addr_flat),
    .layer_done      (layer_done),
    .layer_start     (layer_start),
    .layer_id        (layer_id),
    .layer_addr      (layer_addr),
    .busy            (busy),
    .sw_done         (sw_done),
    .timeout_err     (timeout_err),
    .abort_flag      (abort_flag),
    .total_cycles    (total_cycles),
    .prof_sel        (prof_sel),
    .prof_cycles     (prof_cycles)
  );

  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  int t0  = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    int            id;
    logic [AW-1:0] addr;
    logic          terr;
  } start_t;

  typedef struct {
    int            cyc;
    logic [CW-1:0] total;
    logic          terr;
    logic          aflag;
    logic          busy;
  } done_t;

  start_t starts[$];
  done_t  dones[$];

  // Datapath emulation knobs.
  int lat [NL];
  int hang_layer  = -1;
  int abort_layer = -1;
  bit stray_en    = 1'b0;
  bit poke_en     = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  int exp_s [NL];
  int exp_end;

  // Event monitor, sampled on the falling edge.
  initial begin : monitor
    forever begin
      @(negedge ap_clk);
      if (layer_start) starts.push_back('{cyc - t0, int'(layer_id), layer_addr, timeout_err});
      if (sw_done)     dones.push_back('{cyc - t0, total_cycles, timeout_err, abort_flag, busy});
    end
  end

  // Datapath responder: layer_done lat[id] cycles after layer_start, plus
  // optional stray strobes, a poke of sw_start, and an abort in a GAP.
  initial begin : responder
    bit pend;
    int due, cur, gap_cyc, poke_due, abort_due;
    pend = 1'b0; due = 0; cur = 0; gap_cyc = -1; poke_due = -1; abort_due = -1;
    forever begin
      @(negedge ap_clk);
      layer_done    = 1'b0;
      sw_start_poke = 1'b0;
      sw_abort      = 1'b0;
      if (!ap_rst_n) begin
        pend = 1'b0; gap_cyc = -1; poke_due = -1; abort_due = -1;
      end else if (layer_start) begin
        pend = 1'b1;
        cur  = int'(layer_id);
        due  = cyc + lat[cur];
        if (stray_en) layer_done = 1'b1;
        if (poke_en && cur == 2) poke_due = cyc + 2;
      end else if (pend && cyc == due) begin
        if (cur != hang_layer) begin
          layer_done = 1'b1;
          pend       = 1'b0;
          gap_cyc    = cyc + 1;
          if (cur == abort_layer) abort_due = cyc + 1;
        end
      end
      if (stray_en && cyc == gap_cyc) begin layer_done = 1'b1; gap_cyc = -1; end
      if (cyc == poke_due)  begin sw_start_poke = 1'b1; poke_due = -1; end
      if (cyc == abort_due) begin sw_abort = 1'b1; abort_due = -1; end
    end
  end

  task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_cfg();
    hang_layer = -1; abort_layer = -1; stray_en = 1'b0; poke_en = 1'b0;
    for (int i = 0; i < NL; i++) lat[i] = 10;
  endtask

  task automatic randomize_addrs();
    for (int i = 0; i < NL; i++)
      addr_flat[i*AW +: AW] = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  // Start of layer i+1 = done of layer i + 1 + GAP; run ends one cycle after the last done.
  task automatic model_run();
    int s;
    s = 1;
    for (int i = 0; i < NL; i++) begin
      exp_s[i] = s;
      s = s + lat[i] + 1 + int'(GAP);
    end
    exp_end = exp_s[NL-1] + lat[NL-1] + 1;
  endtask

  task automatic pulse_start();
    starts.delete();
    dones.delete();
    @(negedge ap_clk);
    t0 = cyc;
    sw_start_main = 1'b1;
    @(negedge ap_clk);
    sw_start_main = 1'b0;
  endtask

  task automatic check_starts(input string pfx, input int n_exp);
    check({pfx, "_start_count"}, AW'(starts.size()), AW'(n_exp));
    for (int i = 0; i < n_exp && i < starts.size(); i++) begin
      check($sformatf("%s_start_cyc[%0d]", pfx, i), AW'(starts[i].cyc), AW'(exp_s[i]));
      check($sformatf("%s_start_id[%0d]", pfx, i), AW'(starts[i].id), AW'(i));
      check($sformatf("%s_start_addr[%0d]", pfx, i), starts[i].addr, addr_flat[i*AW +: AW]);
    end
  endtask

  task automatic check_done(input string pfx, input int d_cyc, input int total, input logic terr);
    check({pfx, "_done_count"}, AW'(dones.size()), AW'(1));
    if (dones.size() > 0) begin
      check({pfx, "_done_cyc"}, AW'(dones[0].cyc), AW'(d_cyc));
      check({pfx, "_total"}, AW'(dones[0].total), AW'(total));
      check({pfx, "_terr"}, AW'(dones[0].terr), AW'(terr));
      check({pfx, "_aflag"}, AW'(dones[0].aflag), AW'(0));
      check({pfx, "_busy_at_done"}, AW'(dones[0].busy), AW'(0));
    end
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_layer_start"}, AW'(layer_start), AW'(0));
    check({pfx, "_layer_id"}, AW'(layer_id), AW'(0));
    check({pfx, "_layer_addr"}, layer_addr, AW'(0));
    check({pfx, "_busy"}, AW'(busy), AW'(0));
    check({pfx, "_sw_done"}, AW'(sw_done), AW'(0));
    check({pfx, "_timeout_err"}, AW'(timeout_err), AW'(0));
    check({pfx, "_abort_flag"}, AW'(abort_flag), AW'(0));
    check({pfx, "_total"}, AW'(total_cycles), AW'(0));
    check({pfx, "_prof"}, AW'(prof_cycles), AW'(0));
  endtask

  task automatic check_profile(input string pfx, input int n);
`ifdef SNAP_LAYER_PROFILE_EN
    for (int i = 0; i < n; i++) begin
      @(negedge ap_clk);
      prof_sel = IW'(i);
      #1;
      check($sformatf("%s_prof[%0d]", pfx, i), AW'(prof_cycles), AW'(lat[i]));
    end
    @(negedge ap_clk);
    prof_sel = IW'(25);
    #1;
    check({pfx, "_prof_oob"}, AW'(prof_cycles), AW'(0));
`else
    for (int i = 0; i < 3; i++) begin
      @(negedge ap_clk);
      prof_sel = IW'($urandom_range(n - 1, 0));
      #1;
      check({pfx, "_prof_tied"}, AW'(prof_cycles), AW'(0));
    end
`endif
  endtask

  initial begin : guard
    #1_000_000;
    $display("FAIL global_time_limit: observed running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    reset_cfg();
    randomize_addrs();
    repeat (3) @(negedge ap_clk);
    check_zero("reset");
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (2) @(negedge ap_clk);

    // Normal run: latency 10 everywhere.
    model_run();
    pulse_start();
    repeat (exp_end + 8) @(negedge ap_clk);
    check_starts("normal", NL);
    check_done("normal", exp_end, exp_end - 1, 1'b0);
    if (starts.size() == NL) check("normal_last_start_cyc", AW'(starts[NL-1].cyc), AW'(274));
    check_profile("normal", NL);

    // Watchdog: layer 3 never completes.
    reset_cfg();
    hang_layer = 3;
    model_run();
    pulse_start();
    repeat (exp_s[3] + int'(TO) + 20) @(negedge ap_clk);
    check_starts("wdog", 4);
    check_done("wdog", exp_s[3] + int'(TO) + 1, exp_s[3] + int'(TO), 1'b1);
    check("wdog_terr_sticky", AW'(timeout_err), AW'(1));
    lat[3] = int'(TO);
    check_profile("wdog", 4);

    // Abort in the GAP after layer 5.
    reset_cfg();
    abort_layer = 5;
    randomize_addrs();
    model_run();
    pulse_start();
    if (starts.size() > 0) check("abort_terr_cleared", AW'(starts[0].terr), AW'(0));
    repeat (exp_s[5] + lat[5] + 2 - 1) @(negedge ap_clk);
    check("abort_busy", AW'(busy), AW'(0));
    check("abort_flag", AW'(abort_flag), AW'(1));
    check("abort_no_start", AW'(layer_start), AW'(0));
    repeat (40) @(negedge ap_clk);
    check_starts("abort", 6);
    check("abort_done_count", AW'(dones.size()), AW'(0));
    check("abort_total", AW'(total_cycles), AW'(exp_s[5] + lat[5] + 1));
    check("abort_flag_sticky", AW'(abort_flag), AW'(1));

    // Random latencies with ignored strobes (stray dones, sw_start in WAIT).
    reset_cfg();
    stray_en = 1'b1;
    poke_en  = 1'b1;
    for (int i = 0; i < NL; i++) lat[i] = int'($urandom_range(20, 2));
    randomize_addrs();
    model_run();
    pulse_start();
    repeat (exp_end + 8) @(negedge ap_clk);
    check_starts("strobe", NL);
    check_done("strobe", exp_end, exp_end - 1, 1'b0);
    check_profile("strobe", NL);

    // Asynchronous reset mid-WAIT of layer 10.
    reset_cfg();
    model_run();
    pulse_start();
    repeat (exp_s[10] + 4 - 1) @(negedge ap_clk);
    check("pre_reset_id", AW'(layer_id), AW'(10));
    #2;
    ap_rst_n = 1'b0;
    #1;
    check_zero("midrun_reset");
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    starts.delete();
    dones.delete();
    repeat (10) @(negedge ap_clk);
    check("post_reset_starts", AW'(starts.size()), AW'(0));
    check("post_reset_busy", AW'(busy), AW'(0));
    pulse_start();
    repeat (2) @(negedge ap_clk);
    check("restart_count", AW'(starts.size()), AW'(1));
    if (starts.size() > 0) begin
      check("restart_cyc", AW'(starts[0].cyc), AW'(1));
      check("restart_id", AW'(starts[0].id), AW'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
